// File: rtl/copperv_pkg.sv
// Shared types for the core memory bus arbiter: source identifiers and
// the command payload bundle used by the grant mux.
package copperv_pkg;

   localparam int CPV_ADDR_WIDTH = 32;
   localparam int CPV_DATA_WIDTH = 32;
   localparam int CPV_STRB_WIDTH = CPV_DATA_WIDTH / 8;

   // Which requester a command/response belongs to.
   typedef enum logic {
      ARB_SRC_IF = 1'b0,
      ARB_SRC_DT = 1'b1
   } arb_src_e;

   // Memory command payload; sized by the package widths above, which the
   // arbiter's width parameters default to.
   typedef struct packed {
      logic [CPV_ADDR_WIDTH-1:0] addr;
      logic [CPV_DATA_WIDTH-1:0] wdata;
      logic                      we;
      logic [CPV_STRB_WIDTH-1:0] wstrb;
   } bus_cmd_t;

endpackage

// File: rtl/bus_arb_order_fifo.sv
// DEPTH x 1-bit order FIFO remembering which port issued each outstanding
// memory command. Pushes while full and pops while empty are ignored.
module bus_arb_order_fifo #(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic             din,
   output logic             head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [DEPTH-1:0] slot_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Pointers wrap explicitly so non-power-of-two or single-entry depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign head      = slot_r[rd_ptr_r];
   assign count     = count_r;

   // Entry storage: write the source id at the tail on push.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_r <= {DEPTH{1'b0}};
      end else if (do_push_s) begin
         slot_r[wr_ptr_r] <= din;
      end else begin
         slot_r <= slot_r;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= ptr_next(wr_ptr_r);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/bus_arbiter_checker.sv
// Simulation-time protocol checks for bus_arbiter. A memory response with
// no outstanding command is dropped by the arbiter; this flags it.
module bus_arbiter_checker #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input logic             clk,
   input logic             rstn,
   input logic             mem_rsp_valid,
   input logic             fifo_empty,
   input logic [CNT_W-1:0] fifo_count
);

   rsp_on_empty_a: assert property (@(posedge clk) disable iff (!rstn)
      !(mem_rsp_valid && fifo_empty))
      else $warning("bus_arbiter: memory response with no outstanding command dropped");

   count_bound_a: assert property (@(posedge clk) disable iff (!rstn)
      fifo_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/bus_arbiter.sv
// Core memory bus arbiter: shares one memory port between instruction
// fetch (read-only) and the data port (load/store). Commands pass through
// combinationally, an order FIFO records the issuing port of each accepted
// command, and in-order responses are steered back to that port.
// Build option: COPPERV_ARB_DATA_PRIORITY_EN -- when defined the data port
// always wins a contested cycle instead of round-robin.
module bus_arbiter
   import copperv_pkg::*;
#(
   parameter int ADDR_WIDTH        = CPV_ADDR_WIDTH,
   parameter int DATA_WIDTH        = CPV_DATA_WIDTH,
   parameter int OUTSTANDING_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ADDR_WIDTH-1:0]   if_cmd_addr,
   input  logic                    if_cmd_valid,
   output logic                    if_cmd_ready,
   output logic [DATA_WIDTH-1:0]   if_rsp_rdata,
   output logic                    if_rsp_valid,
   input  logic [ADDR_WIDTH-1:0]   dt_cmd_addr,
   input  logic [DATA_WIDTH-1:0]   dt_cmd_wdata,
   input  logic                    dt_cmd_we,
   input  logic [DATA_WIDTH/8-1:0] dt_cmd_wstrb,
   input  logic                    dt_cmd_valid,
   output logic                    dt_cmd_ready,
   output logic [DATA_WIDTH-1:0]   dt_rsp_rdata,
   output logic                    dt_rsp_valid,
   output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
   output logic [DATA_WIDTH-1:0]   mem_cmd_wdata,
   output logic                    mem_cmd_we,
   output logic [DATA_WIDTH/8-1:0] mem_cmd_wstrb,
   output logic                    mem_cmd_valid,
   input  logic                    mem_cmd_ready,
   input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
   input  logic                    mem_rsp_valid
);

   localparam int CNT_W = $clog2(OUTSTANDING_DEPTH + 1);

   arb_src_e         grant_src_s;
   logic             grant_valid_s;
   arb_src_e         rr_ptr_s;
   bus_cmd_t         cmd_s;
   logic             accept_s;
   logic             lock_r;
   arb_src_e         lock_src_r;
   logic             fifo_head_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic             rsp_fire_s;

`ifdef COPPERV_ARB_DATA_PRIORITY_EN
   // Fixed priority: a contested cycle always goes to the data port.
   assign rr_ptr_s = ARB_SRC_DT;
`else
   arb_src_e rr_ptr_r;

   // Round-robin pointer flips to the other source after every acceptance.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_r <= ARB_SRC_IF;
      end else if (accept_s) begin
         rr_ptr_r <= (grant_src_s == ARB_SRC_IF) ? ARB_SRC_DT : ARB_SRC_IF;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   assign rr_ptr_s = rr_ptr_r;
`endif

   // Grant selection: a stalled grant stays locked, otherwise the lone
   // requester or the arbitration winner; nothing is granted in reset.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_src_s   = ARB_SRC_IF;
      if (!rstn) begin
         grant_valid_s = 1'b0;
      end else if (lock_r) begin
         grant_src_s   = lock_src_r;
         grant_valid_s = (lock_src_r == ARB_SRC_DT) ? dt_cmd_valid : if_cmd_valid;
      end else if (if_cmd_valid && dt_cmd_valid) begin
         grant_src_s   = rr_ptr_s;
         grant_valid_s = 1'b1;
      end else if (if_cmd_valid) begin
         grant_src_s   = ARB_SRC_IF;
         grant_valid_s = 1'b1;
      end else if (dt_cmd_valid) begin
         grant_src_s   = ARB_SRC_DT;
         grant_valid_s = 1'b1;
      end else begin
         grant_valid_s = 1'b0;
      end
   end

   // Payload mux: fetches carry no store data; no grant drives zeros.
   always_comb begin
      cmd_s = '0;
      if (grant_valid_s) begin
         case (grant_src_s)
            ARB_SRC_IF: begin
               cmd_s.addr = if_cmd_addr;
            end
            ARB_SRC_DT: begin
               cmd_s.addr  = dt_cmd_addr;
               cmd_s.wdata = dt_cmd_wdata;
               cmd_s.we    = dt_cmd_we;
               cmd_s.wstrb = dt_cmd_wstrb;
            end
            default: cmd_s = '0;
         endcase
      end else begin
         cmd_s = '0;
      end
   end

   assign mem_cmd_valid = grant_valid_s && !fifo_full_s;
   assign accept_s      = mem_cmd_valid && mem_cmd_ready;
   assign if_cmd_ready  = accept_s && (grant_src_s == ARB_SRC_IF);
   assign dt_cmd_ready  = accept_s && (grant_src_s == ARB_SRC_DT);
   assign mem_cmd_addr  = cmd_s.addr;
   assign mem_cmd_wdata = cmd_s.wdata;
   assign mem_cmd_we    = cmd_s.we;
   assign mem_cmd_wstrb = cmd_s.wstrb;

   // Lock holds the granted source while memory back-pressures a command.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_r     <= 1'b0;
         lock_src_r <= ARB_SRC_IF;
      end else if (mem_cmd_valid && !mem_cmd_ready) begin
         lock_r     <= 1'b1;
         lock_src_r <= grant_src_s;
      end else if (accept_s) begin
         lock_r     <= 1'b0;
         lock_src_r <= lock_src_r;
      end else begin
         lock_r     <= lock_r;
         lock_src_r <= lock_src_r;
      end
   end

   bus_arb_order_fifo #(
      .DEPTH (OUTSTANDING_DEPTH)
   ) u_order_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (accept_s),
      .pop   (mem_rsp_valid),
      .din   (grant_src_s),
      .head  (fifo_head_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   // A response with nothing outstanding is dropped silently.
   assign rsp_fire_s = mem_rsp_valid && !fifo_empty_s;

   // Response steering: the FIFO head names the port that owns this response.
   always_comb begin
      if_rsp_valid = 1'b0;
      if_rsp_rdata = {DATA_WIDTH{1'b0}};
      dt_rsp_valid = 1'b0;
      dt_rsp_rdata = {DATA_WIDTH{1'b0}};
      if (rsp_fire_s) begin
         if (arb_src_e'(fifo_head_s) == ARB_SRC_DT) begin
            dt_rsp_valid = 1'b1;
            dt_rsp_rdata = mem_rsp_rdata;
         end else begin
            if_rsp_valid = 1'b1;
            if_rsp_rdata = mem_rsp_rdata;
         end
      end else begin
         if_rsp_valid = 1'b0;
         dt_rsp_valid = 1'b0;
      end
   end

   bus_arbiter_checker #(
      .DEPTH (OUTSTANDING_DEPTH),
      .CNT_W (CNT_W)
   ) u_checker (
      .clk           (clk),
      .rstn          (rstn),
      .mem_rsp_valid (mem_rsp_valid),
      .fifo_empty    (fifo_empty_s),
      .fifo_count    (fifo_count_s)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: stimulus pushes expected
// memory commands and responses into queues, a negedge monitor pops and
// compares whenever the DUT presents a handshake or response.
module tb_bus_arbiter;

`ifdef COPPERV_ARB_DATA_PRIORITY_EN
   localparam bit PRIO_DT = 1'b1;
`else
   localparam bit PRIO_DT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] if_cmd_addr;
   logic        if_cmd_valid;
   logic        if_cmd_ready;
   logic [31:0] if_rsp_rdata;
   logic        if_rsp_valid;
   logic [31:0] dt_cmd_addr;
   logic [31:0] dt_cmd_wdata;
   logic        dt_cmd_we;
   logic [3:0]  dt_cmd_wstrb;
   logic        dt_cmd_valid;
   logic        dt_cmd_ready;
   logic [31:0] dt_rsp_rdata;
   logic        dt_rsp_valid;
   logic [31:0] mem_cmd_addr;
   logic [31:0] mem_cmd_wdata;
   logic        mem_cmd_we;
   logic [3:0]  mem_cmd_wstrb;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready;
   logic [31:0] mem_rsp_rdata;
   logic        mem_rsp_valid;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  wstrb;
   } cmd_t;

   cmd_t        exp_cmd_q[$];
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dt_q[$];
   cmd_t        mon_cmd;
   logic [31:0] mon_data;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   bus_arbiter dut (
      .clk           (clk),
      .rstn          (rstn),
      .if_cmd_addr   (if_cmd_addr),
      .if_cmd_valid  (if_cmd_valid),
      .if_cmd_ready  (if_cmd_ready),
      .if_rsp_rdata  (if_rsp_rdata),
      .if_rsp_valid  (if_rsp_valid),
      .dt_cmd_addr   (dt_cmd_addr),
      .dt_cmd_wdata  (dt_cmd_wdata),
      .dt_cmd_we     (dt_cmd_we),
      .dt_cmd_wstrb  (dt_cmd_wstrb),
      .dt_cmd_valid  (dt_cmd_valid),
      .dt_cmd_ready  (dt_cmd_ready),
      .dt_rsp_rdata  (dt_rsp_rdata),
      .dt_rsp_valid  (dt_rsp_valid),
      .mem_cmd_addr  (mem_cmd_addr),
      .mem_cmd_wdata (mem_cmd_wdata),
      .mem_cmd_we    (mem_cmd_we),
      .mem_cmd_wstrb (mem_cmd_wstrb),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_ready (mem_cmd_ready),
      .mem_rsp_rdata (mem_rsp_rdata),
      .mem_rsp_valid (mem_rsp_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] wd,
                           input logic we, input logic [3:0] st);
      cmd_t c;
      c.addr = a; c.wdata = wd; c.we = we; c.wstrb = st;
      exp_cmd_q.push_back(c);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_mem_valid"}, 32'(mem_cmd_valid), 32'd0);
      check({tag, "_if_rdy"},    32'(if_cmd_ready),  32'd0);
      check({tag, "_dt_rdy"},    32'(dt_cmd_ready),  32'd0);
      check({tag, "_if_rsp"},    32'(if_rsp_valid),  32'd0);
      check({tag, "_dt_rsp"},    32'(dt_rsp_valid),  32'd0);
      check({tag, "_addr"},      mem_cmd_addr,       32'd0);
      check({tag, "_wdata"},     mem_cmd_wdata,      32'd0);
      check({tag, "_we"},        32'(mem_cmd_we),    32'd0);
      check({tag, "_wstrb"},     32'(mem_cmd_wstrb), 32'd0);
   endtask

   task automatic rsp_cycle(input logic [31:0] d, input bit to_dt);
      if (to_dt) exp_dt_q.push_back(d);
      else       exp_if_q.push_back(d);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = d;
      @(negedge clk);
      check("rsp_other_quiet", 32'(to_dt ? if_rsp_valid : dt_rsp_valid), 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'd0;
   endtask

   task automatic issue_if(input logic [31:0] a);
      push_exp(a, 32'd0, 1'b0, 4'd0);
      if_cmd_valid = 1'b1; if_cmd_addr = a; mem_cmd_ready = 1'b1;
      @(negedge clk);
      check("issue_if_rdy", 32'(if_cmd_ready), 32'd1);
      check("issue_if_dt_rdy", 32'(dt_cmd_ready), 32'd0);
      tick();
      if_cmd_valid = 1'b0; mem_cmd_ready = 1'b0;
   endtask

   task automatic issue_dt(input logic [31:0] a, input logic [31:0] wd,
                           input logic we, input logic [3:0] st);
      push_exp(a, wd, we, st);
      dt_cmd_valid = 1'b1; dt_cmd_addr = a; dt_cmd_wdata = wd;
      dt_cmd_we = we; dt_cmd_wstrb = st; mem_cmd_ready = 1'b1;
      @(negedge clk);
      check("issue_dt_rdy", 32'(dt_cmd_ready), 32'd1);
      check("issue_dt_if_rdy", 32'(if_cmd_ready), 32'd0);
      tick();
      dt_cmd_valid = 1'b0; dt_cmd_we = 1'b0; dt_cmd_wdata = 32'd0;
      dt_cmd_wstrb = 4'd0; mem_cmd_ready = 1'b0;
   endtask

   // Both ports request together; the first winner may be stalled by memory.
   task automatic pair(input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] ird, input logic [31:0] drd, input int stall);
      logic [31:0] fa;
      fa = PRIO_DT ? da : ia;
      if (PRIO_DT) begin
         push_exp(da, 32'd0, 1'b0, 4'd0);
         push_exp(ia, 32'd0, 1'b0, 4'd0);
      end else begin
         push_exp(ia, 32'd0, 1'b0, 4'd0);
         push_exp(da, 32'd0, 1'b0, 4'd0);
      end
      if_cmd_valid = 1'b1; if_cmd_addr = ia;
      dt_cmd_valid = 1'b1; dt_cmd_addr = da; dt_cmd_we = 1'b0;
      dt_cmd_wdata = 32'd0; dt_cmd_wstrb = 4'd0;
      mem_cmd_ready = (stall == 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid",  32'(mem_cmd_valid), 32'd1);
         check("stall_addr",   mem_cmd_addr,       fa);
         check("stall_if_rdy", 32'(if_cmd_ready),  32'd0);
         check("stall_dt_rdy", 32'(dt_cmd_ready),  32'd0);
         tick();
      end
      mem_cmd_ready = 1'b1;
      @(negedge clk);
      check("first_if_rdy", 32'(if_cmd_ready), 32'(!PRIO_DT));
      check("first_dt_rdy", 32'(dt_cmd_ready), 32'(PRIO_DT));
      tick();
      if (PRIO_DT) dt_cmd_valid = 1'b0;
      else         if_cmd_valid = 1'b0;
      @(negedge clk);
      check("second_if_rdy", 32'(if_cmd_ready), 32'(PRIO_DT));
      check("second_dt_rdy", 32'(dt_cmd_ready), 32'(!PRIO_DT));
      tick();
      if_cmd_valid = 1'b0; dt_cmd_valid = 1'b0; mem_cmd_ready = 1'b0;
      rsp_cycle(PRIO_DT ? drd : ird, PRIO_DT);
      rsp_cycle(PRIO_DT ? ird : drd, !PRIO_DT);
   endtask

   // Scoreboard monitor: pop and compare on every command handshake/response.
   always @(negedge clk) begin
      if (rstn) begin
         if (mem_cmd_valid && mem_cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
               check("cmd_unexpected", 32'(mem_cmd_valid), 32'd0);
            end else begin
               mon_cmd = exp_cmd_q.pop_front();
               check("cmd_addr",  mem_cmd_addr,       mon_cmd.addr);
               check("cmd_wdata", mem_cmd_wdata,      mon_cmd.wdata);
               check("cmd_we",    32'(mem_cmd_we),    32'(mon_cmd.we));
               check("cmd_wstrb", 32'(mem_cmd_wstrb), 32'(mon_cmd.wstrb));
            end
         end
         if (if_rsp_valid) begin
            if (exp_if_q.size() == 0) begin
               check("if_rsp_unexpected", 32'(if_rsp_valid), 32'd0);
            end else begin
               mon_data = exp_if_q.pop_front();
               check("if_rsp_rdata", if_rsp_rdata, mon_data);
               check("if_rsp_dt_rdata_zero", dt_rsp_rdata, 32'd0);
            end
         end
         if (dt_rsp_valid) begin
            if (exp_dt_q.size() == 0) begin
               check("dt_rsp_unexpected", 32'(dt_rsp_valid), 32'd0);
            end else begin
               mon_data = exp_dt_q.pop_front();
               check("dt_rsp_rdata", dt_rsp_rdata, mon_data);
               check("dt_rsp_if_rdata_zero", if_rsp_rdata, 32'd0);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      rstn = 1'b0;
      if_cmd_valid = 1'b1; if_cmd_addr = 32'h100;
      dt_cmd_valid = 1'b1; dt_cmd_addr = 32'h2000; dt_cmd_wdata = 32'h55;
      dt_cmd_we = 1'b1; dt_cmd_wstrb = 4'hF;
      mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234;
      @(negedge clk);
      check_idle("reset");
      tick();
      if_cmd_valid = 1'b0; dt_cmd_valid = 1'b0; dt_cmd_we = 1'b0;
      dt_cmd_wdata = 32'd0; dt_cmd_wstrb = 4'd0;
      mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
      rstn = 1'b1;
      tick();

      // Contested start: rr_ptr comes out of reset pointing at fetch.
      pair(32'h100, 32'h2000, 32'h1111, 32'h2222, 0);
      // Memory stalls the first winner for three cycles.
      pair(32'h300, 32'h400, 32'h3333, 32'h4444, 3);

      // Fill the order FIFO, third command waits for a slot.
      issue_if(32'h10);
      issue_dt(32'h20, 32'd0, 1'b0, 4'd0);
      push_exp(32'h30, 32'd0, 1'b0, 4'd0);
      if_cmd_valid = 1'b1; if_cmd_addr = 32'h30; mem_cmd_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("full_mem_valid", 32'(mem_cmd_valid), 32'd0);
         check("full_if_rdy",    32'(if_cmd_ready),  32'd0);
         tick();
      end
      exp_if_q.push_back(32'hAAAA);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAAAA;
      @(negedge clk);
      check("pop_no_unblock", 32'(mem_cmd_valid), 32'd0);
      check("pop_dt_quiet",   32'(dt_rsp_valid),  32'd0);
      tick();
      exp_dt_q.push_back(32'hBBBB);
      mem_rsp_rdata = 32'hBBBB;
      @(negedge clk);
      check("pushpop_mem_valid", 32'(mem_cmd_valid), 32'd1);
      check("pushpop_if_rdy",    32'(if_cmd_ready),  32'd1);
      tick();
      if_cmd_valid = 1'b0; mem_cmd_ready = 1'b0;
      rsp_cycle(32'hCCCC, 1'b0);

      // Response with nothing outstanding is dropped.
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD;
      @(negedge clk);
      check("empty_if_rsp", 32'(if_rsp_valid), 32'd0);
      check("empty_dt_rsp", 32'(dt_rsp_valid), 32'd0);
      tick();
      mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;

      // Store: payload passes through, response goes to the data port only.
      issue_dt(32'h40, 32'hDEADBEEF, 1'b1, 4'b0011);
      rsp_cycle(32'h12345678, 1'b1);

      // Lock: stalled data command keeps the bus even when fetch joins in.
      push_exp(32'h500, 32'd0, 1'b0, 4'd0);
      push_exp(32'h600, 32'd0, 1'b0, 4'd0);
      dt_cmd_valid = 1'b1; dt_cmd_addr = 32'h500; mem_cmd_ready = 1'b0;
      @(negedge clk);
      check("lock_addr0", mem_cmd_addr, 32'h500);
      check("lock_dt_rdy0", 32'(dt_cmd_ready), 32'd0);
      tick();
      if_cmd_valid = 1'b1; if_cmd_addr = 32'h600;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("lock_addr", mem_cmd_addr, 32'h500);
         check("lock_if_rdy", 32'(if_cmd_ready), 32'd0);
         tick();
      end
      mem_cmd_ready = 1'b1;
      @(negedge clk);
      check("lock_dt_accept", 32'(dt_cmd_ready), 32'd1);
      tick();
      dt_cmd_valid = 1'b0;
      @(negedge clk);
      check("lock_if_accept", 32'(if_cmd_ready), 32'd1);
      tick();
      if_cmd_valid = 1'b0; mem_cmd_ready = 1'b0;
      rsp_cycle(32'h5555, 1'b1);
      rsp_cycle(32'h6666, 1'b0);

      // Reset with two commands outstanding and rr_ptr pointing at data.
      issue_dt(32'h60, 32'd0, 1'b0, 4'd0);
      issue_if(32'h50);
      if_cmd_valid = 1'b1; if_cmd_addr = 32'h90;
      dt_cmd_valid = 1'b1; dt_cmd_addr = 32'hA0; dt_cmd_we = 1'b1;
      dt_cmd_wdata = 32'h77; dt_cmd_wstrb = 4'hF;
      mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h99;
      rstn = 1'b0;
      @(negedge clk);
      check_idle("midreset");
      tick();
      rstn = 1'b1;
      if_cmd_valid = 1'b0; dt_cmd_valid = 1'b0; dt_cmd_we = 1'b0;
      dt_cmd_wdata = 32'd0; dt_cmd_wstrb = 4'd0; mem_cmd_ready = 1'b0;
      mem_rsp_rdata = 32'hBAD;
      @(negedge clk);
      check("late_if_rsp", 32'(if_rsp_valid), 32'd0);
      check("late_dt_rsp", 32'(dt_rsp_valid), 32'd0);
      tick();
      mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
      // FIFO must be empty and rr_ptr back at fetch.
      pair(32'h700, 32'h800, 32'h7777, 32'h8888, 0);

      tick();
      check("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
      check("if_q_drained",  32'(exp_if_q.size()),  32'd0);
      check("dt_q_drained",  32'(exp_dt_q.size()),  32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
